// File: rtl/mem_pkg.sv
// ------------------------------------------------------------------
// mem_pkg: memory-bus widths/constants and arbiter state encoding.  rev 1.0
// ------------------------------------------------------------------
`default_nettype none

`ifndef MEM_DEF_SVH
`define MEM_DEF_SVH
`define ADDR_BUS  31:0
`define DATA_BUS  31:0
`define TRUE      1'b1
`define FALSE     1'b0
`define ZERO_WORD 32'h0000_0000
`endif

package mem_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_BUSY = 2'd1,
    ARB_GAP  = 2'd2
  } arb_state_t;

endpackage

`default_nettype wire

// File: rtl/rr_pick2.sv
// ------------------------------------------------------------------
// rr_pick2: combinational two-way request picker (0 = port 0, 1 = port 1).  rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module rr_pick2 (
  input  logic [1:0] req,
  input  logic       last,
  input  logic       rr_en,
  output logic       grant
);

  // On a tie, round-robin hands the bus to the port that did not go last.
  always_comb begin
    grant = 1'b0;
    if (req == 2'b11)
      grant = rr_en & ~last;
    else if (req == 2'b10)
      grant = 1'b1;
  end

endmodule

`default_nettype wire

// File: rtl/mem_arb2.sv
// ------------------------------------------------------------------
// mem_arb2: two-client arbiter serialising accesses onto the bridge mem port.  rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module mem_arb2
  import mem_pkg::*;
#(
  parameter int RR_EN          = 1,
  parameter int TIMEOUT_CYCLES = 0,
  parameter int CNT_W          = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             c0_ce_i,
  input  logic             c0_we_i,
  input  logic [`ADDR_BUS] c0_addr_i,
  input  logic [`DATA_BUS] c0_data_i,
  output logic [`DATA_BUS] c0_data_o,
  output logic             c0_ready_o,
  output logic             c0_err_o,
  input  logic             c1_ce_i,
  input  logic             c1_we_i,
  input  logic [`ADDR_BUS] c1_addr_i,
  input  logic [`DATA_BUS] c1_data_i,
  output logic [`DATA_BUS] c1_data_o,
  output logic             c1_ready_o,
  output logic             c1_err_o,
  output logic             mem_ce_o,
  output logic             mem_we_o,
  output logic [`ADDR_BUS] mem_addr_o,
  output logic [`DATA_BUS] mem_data_o,
  input  logic [`DATA_BUS] mem_data_i,
  input  logic             mem_ready_i
);

  arb_state_t       state;
  logic             last_grant;
  logic             grant;
  logic [CNT_W-1:0] cnt;
  logic             pick;
  logic             timed_out;
  logic             done;
  logic [`DATA_BUS] done_data;

  rr_pick2 u_pick (
    .req   ({c1_ce_i, c0_ce_i}),
    .last  (last_grant),
    .rr_en (RR_EN != 0),
    .grant (pick)
  );

  assign timed_out = (TIMEOUT_CYCLES != 0) && (cnt == CNT_W'(TIMEOUT_CYCLES));
  assign done      = mem_ready_i || timed_out;
  // Writes and aborted accesses hand back a zero word rather than bus noise.
  assign done_data = (mem_ready_i && !mem_we_o) ? mem_data_i : `ZERO_WORD;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ARB_IDLE;
      last_grant <= 1'b1;
      grant      <= 1'b0;
      cnt        <= '0;
      mem_ce_o   <= 1'b0;
      mem_we_o   <= 1'b0;
      mem_addr_o <= '0;
      mem_data_o <= '0;
      c0_data_o  <= '0;
      c0_ready_o <= 1'b0;
      c0_err_o   <= 1'b0;
      c1_data_o  <= '0;
      c1_ready_o <= 1'b0;
      c1_err_o   <= 1'b0;
    end else begin
      c0_ready_o <= 1'b0;
      c0_err_o   <= 1'b0;
      c1_ready_o <= 1'b0;
      c1_err_o   <= 1'b0;
      case (state)
        ARB_IDLE: begin
          if (c0_ce_i || c1_ce_i) begin
            grant      <= pick;
            mem_ce_o   <= 1'b1;
            mem_we_o   <= pick ? c1_we_i   : c0_we_i;
            mem_addr_o <= pick ? c1_addr_i : c0_addr_i;
            mem_data_o <= pick ? c1_data_i : c0_data_i;
            cnt        <= '0;
            state      <= ARB_BUSY;
          end
        end
        ARB_BUSY: begin
          if (done) begin
            if (grant) begin
              c1_ready_o <= 1'b1;
              c1_err_o   <= !mem_ready_i;
              c1_data_o  <= done_data;
            end else begin
              c0_ready_o <= 1'b1;
              c0_err_o   <= !mem_ready_i;
              c0_data_o  <= done_data;
            end
            mem_ce_o   <= 1'b0;
            last_grant <= grant;
            state      <= ARB_GAP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ARB_GAP:  state <= ARB_IDLE;
        default:  state <= ARB_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire
